// File: rtl/axil_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite register bank.
package axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [4:0] ADDR_REG0   = 5'h00;
   localparam logic [4:0] ADDR_REG1   = 5'h04;
   localparam logic [4:0] ADDR_REG2   = 5'h08;
   localparam logic [4:0] ADDR_REG3   = 5'h0C;
   localparam logic [4:0] ADDR_STATUS = 5'h10;

   typedef enum logic {W_IDLE, W_RESP} wr_state_t;
   typedef enum logic {R_IDLE, R_DATA} rd_state_t;

   // Word index used for decode; the two byte-offset bits never matter.
   function automatic logic [2:0] word_idx(input logic [4:0] addr);
      return addr[4:2];
   endfunction

endpackage

// File: rtl/axil_wstrb_merge.sv
// Byte-lane merge: each lane takes WDATA when its strobe is set, else keeps old data.
module axil_wstrb_merge #(
   parameter int unsigned DW = 32
) (
   input  logic [DW-1:0]   old_data,
   input  logic [DW-1:0]   wdata,
   input  logic [DW/8-1:0] wstrb,
   output logic [DW-1:0]   merged
);

   for (genvar b = 0; b < DW/8; b++) begin : g_lane
      assign merged[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : old_data[8*b +: 8];
   end

endmodule

// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave with C_NUM_REGS R/W registers and independent read/write FSMs.
// Optional read-only status word at 0x10 when AXIL_REG_BANK_STATUS_EN is defined.
module axil_reg_bank
   import axil_pkg::*;
#(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
   parameter int unsigned C_NUM_REGS         = 4,
   parameter logic [31:0] C_RESET_VAL        = 32'h0
) (
   input  logic                              ACLK,
   input  logic                              ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic [32*C_NUM_REGS-1:0]          regs_o,
   input  logic [31:0]                       status_i
);

   localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
   localparam int unsigned SW = DW/8;
   localparam logic [2:0]  STATUS_IDX = word_idx(ADDR_STATUS);

   logic [C_NUM_REGS-1:0][DW-1:0] regs;

   wr_state_t       w_state;
   logic            awready_q, wready_q, bvalid_q;
   logic [1:0]      bresp_q;
   logic            aw_held, w_held;
   logic [2:0]      aw_idx_q;
   logic [DW-1:0]   wdata_q;
   logic [SW-1:0]   wstrb_q;

   rd_state_t       r_state;
   logic            arready_q, rvalid_q;
   logic [DW-1:0]   rdata_q;
   logic [1:0]      rresp_q;

   logic            aw_fire, w_fire, ar_fire, commit;
   logic [2:0]      wr_idx, rd_idx;
   logic [DW-1:0]   wr_data, old_data, merged, rd_val;
   logic [SW-1:0]   wr_strb;
   logic            wr_hit;
   logic [1:0]      rd_resp;

   assign aw_fire = S_AXI_AWVALID & awready_q;
   assign w_fire  = S_AXI_WVALID  & wready_q;
   assign ar_fire = S_AXI_ARVALID & arready_q;

   // A beat captured in an earlier cycle takes priority over the live bus.
   assign wr_idx  = aw_held ? aw_idx_q : word_idx(S_AXI_AWADDR[4:0]);
   assign wr_data = w_held  ? wdata_q  : S_AXI_WDATA;
   assign wr_strb = w_held  ? wstrb_q  : S_AXI_WSTRB;
   assign commit  = (w_state == W_IDLE) & (aw_held | aw_fire) & (w_held | w_fire);
   assign rd_idx  = word_idx(S_AXI_ARADDR[4:0]);

   always_comb begin
      wr_hit   = 1'b0;
      old_data = '0;
      for (int i = 0; i < int'(C_NUM_REGS); i++) begin
         if (wr_idx == i[2:0]) begin
            wr_hit   = 1'b1;
            old_data = regs[i];
         end
      end
   end

   always_comb begin
      rd_val  = '0;
      rd_resp = RESP_SLVERR;
      for (int i = 0; i < int'(C_NUM_REGS); i++) begin
         if (rd_idx == i[2:0]) begin
            rd_val  = regs[i];
            rd_resp = RESP_OKAY;
         end
      end
`ifdef AXIL_REG_BANK_STATUS_EN
      if (rd_idx == STATUS_IDX && 32'(rd_idx) >= C_NUM_REGS) begin
         rd_val  = status_i;
         rd_resp = RESP_OKAY;
      end
`endif
   end

   axil_wstrb_merge #(.DW(DW)) u_merge (
      .old_data (old_data),
      .wdata    (wr_data),
      .wstrb    (wr_strb),
      .merged   (merged)
   );

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         for (int i = 0; i < int'(C_NUM_REGS); i++) regs[i] <= C_RESET_VAL;
      end else if (commit && wr_hit) begin
         for (int i = 0; i < int'(C_NUM_REGS); i++)
            if (wr_idx == i[2:0]) regs[i] <= merged;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         w_state   <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         aw_idx_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (commit) begin
                  w_state   <= W_RESP;
                  bvalid_q  <= 1'b1;
                  bresp_q   <= wr_hit ? RESP_OKAY : RESP_SLVERR;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  aw_held   <= 1'b0;
                  w_held    <= 1'b0;
               end else begin
                  if (aw_fire) begin
                     aw_held   <= 1'b1;
                     aw_idx_q  <= word_idx(S_AXI_AWADDR[4:0]);
                     awready_q <= 1'b0;
                  end else begin
                     awready_q <= ~aw_held;
                  end
                  if (w_fire) begin
                     w_held   <= 1'b1;
                     wdata_q  <= S_AXI_WDATA;
                     wstrb_q  <= S_AXI_WSTRB;
                     wready_q <= 1'b0;
                  end else begin
                     wready_q <= ~w_held;
                  end
               end
            end
            W_RESP: begin
               if (S_AXI_BREADY) begin
                  w_state   <= W_IDLE;
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Register values are sampled before this edge's write lands, so a
   // colliding read sees the old contents.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state   <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ar_fire) begin
                  r_state   <= R_DATA;
                  rdata_q   <= rd_val;
                  rresp_q   <= rd_resp;
                  rvalid_q  <= 1'b1;
                  arready_q <= 1'b0;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_DATA: begin
               if (S_AXI_RREADY) begin
                  r_state   <= R_IDLE;
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign regs_o        = regs;

   logic unused_ok;
`ifdef AXIL_REG_BANK_STATUS_EN
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                        status_i, STATUS_IDX};
`endif

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed bench for axil_reg_bank; expected B/R responses are queued and checked by a monitor.
module tb_axil_reg_bank;

   logic         ACLK = 1'b0;
   logic         ARESET = 1'b1;
   logic [4:0]   S_AXI_AWADDR = '0;
   logic [2:0]   S_AXI_AWPROT = '0;
   logic         S_AXI_AWVALID = 1'b0;
   logic         S_AXI_AWREADY;
   logic [31:0]  S_AXI_WDATA = '0;
   logic [3:0]   S_AXI_WSTRB = '0;
   logic         S_AXI_WVALID = 1'b0;
   logic         S_AXI_WREADY;
   logic [1:0]   S_AXI_BRESP;
   logic         S_AXI_BVALID;
   logic         S_AXI_BREADY = 1'b1;
   logic [4:0]   S_AXI_ARADDR = '0;
   logic [2:0]   S_AXI_ARPROT = '0;
   logic         S_AXI_ARVALID = 1'b0;
   logic         S_AXI_ARREADY;
   logic [31:0]  S_AXI_RDATA;
   logic [1:0]   S_AXI_RRESP;
   logic         S_AXI_RVALID;
   logic         S_AXI_RREADY = 1'b1;
   logic [127:0] regs_o;
   logic [31:0]  status_i = 32'hCAFE_F00D;

   int checks = 0;
   int errors = 0;
   logic [1:0]  exp_b[$];
   logic [33:0] exp_r[$];

   always #5 ACLK = ~ACLK;

   axil_reg_bank dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .regs_o(regs_o), .status_i(status_i)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   // Response monitor: one comparison per completed B or R handshake.
   always @(negedge ACLK) begin
      if (S_AXI_BVALID && S_AXI_BREADY) begin
         if (exp_b.size() == 0) begin
            errors++;
            $display("FAIL unexpected_b got %h want none", S_AXI_BRESP);
         end else chk("bresp", 128'(S_AXI_BRESP), 128'(exp_b.pop_front()));
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
         if (exp_r.size() == 0) begin
            errors++;
            $display("FAIL unexpected_r got %h want none", S_AXI_RDATA);
         end else chk("rdata_rresp", 128'({S_AXI_RDATA, S_AXI_RRESP}), 128'(exp_r.pop_front()));
      end
   end

   task automatic wait_b();
      for (int c = 0; c < 50 && exp_b.size() != 0; c++) @(posedge ACLK);
      #1;
      if (exp_b.size() != 0) begin
         errors++;
         $display("FAIL b_timeout got %0d pending want 0", exp_b.size());
         exp_b.delete();
      end
   endtask

   task automatic wait_r();
      for (int c = 0; c < 50 && exp_r.size() != 0; c++) @(posedge ACLK);
      #1;
      if (exp_r.size() != 0) begin
         errors++;
         $display("FAIL r_timeout got %0d pending want 0", exp_r.size());
         exp_r.delete();
      end
   endtask

   // wd/ad: cycle offsets at which W and AW are first presented.
   task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int wd, input int ad, input logic [1:0] e, input bit wait_resp);
      bit ws = 0, as = 0, wdn = 0, adn = 0;
      exp_b.push_back(e);
      for (int c = 0; c < 100 && !(wdn && adn); c++) begin
         if (!ws && c >= wd) begin S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1; ws = 1; end
         if (!as && c >= ad) begin S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1; as = 1; end
         @(negedge ACLK);
         if (S_AXI_WVALID && S_AXI_WREADY) wdn = 1;
         if (S_AXI_AWVALID && S_AXI_AWREADY) adn = 1;
         @(posedge ACLK); #1;
         if (wdn) S_AXI_WVALID = 1'b0;
         if (adn) S_AXI_AWVALID = 1'b0;
      end
      if (!(wdn && adn)) begin
         errors++;
         $display("FAIL aw_w_timeout got aw=%0d w=%0d want 1 1", adn, wdn);
         S_AXI_WVALID = 1'b0; S_AXI_AWVALID = 1'b0;
      end
      if (wait_resp) wait_b();
   endtask

   task automatic axi_read(input logic [4:0] a, input logic [31:0] d, input logic [1:0] e,
                           input bit wait_resp);
      bit dn = 0;
      exp_r.push_back({d, e});
      S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
      for (int c = 0; c < 100 && !dn; c++) begin
         @(negedge ACLK);
         if (S_AXI_ARREADY) dn = 1;
         @(posedge ACLK); #1;
      end
      S_AXI_ARVALID = 1'b0;
      if (!dn) begin
         errors++;
         $display("FAIL ar_timeout got 0 want 1");
      end
      if (wait_resp) wait_r();
   endtask

   initial begin
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      chk("rst_readys", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(3'b000));
      chk("rst_valids", 128'({S_AXI_BVALID, S_AXI_RVALID}), 128'(2'b00));
      chk("rst_data", 128'({S_AXI_RDATA, S_AXI_RRESP, S_AXI_BRESP}), 128'(0));
      chk("rst_regs", regs_o, 128'(0));
      @(posedge ACLK); #1 ARESET = 1'b0;
      @(posedge ACLK); @(negedge ACLK);
      chk("post_rst_ready", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(3'b111));
      @(posedge ACLK); #1;

      // Basic write/readback
      axi_write(5'h00, 32'h0101FFFF, 4'hF, 0, 0, 2'b00, 1);
      axi_read(5'h00, 32'h0101FFFF, 2'b00, 1);

      // W leads AW by 3 cycles
      axi_write(5'h04, 32'hABCD0001, 4'hF, 0, 3, 2'b00, 1);
      axi_write(5'h08, 32'hDEAD0011, 4'hF, 0, 3, 2'b00, 1);
      axi_write(5'h0C, 32'hBEEF0011, 4'hF, 0, 3, 2'b00, 1);
      chk("regs_after_lead", regs_o, {32'hBEEF0011, 32'hDEAD0011, 32'hABCD0001, 32'h0101FFFF});
      axi_read(5'h04, 32'hABCD0001, 2'b00, 1);
      axi_read(5'h08, 32'hDEAD0011, 2'b00, 1);
      axi_read(5'h0E, 32'hBEEF0011, 2'b00, 1);

      // Partial strobes, AW leading W, and an all-zero strobe
      axi_write(5'h04, 32'hFFFFFFFF, 4'hF, 2, 0, 2'b00, 1);
      axi_write(5'h05, 32'h12345678, 4'b0101, 0, 0, 2'b00, 1);
      axi_read(5'h04, 32'hFF34FF78, 2'b00, 1);
      axi_write(5'h08, 32'h00000000, 4'h0, 0, 0, 2'b00, 1);
      axi_read(5'h08, 32'hDEAD0011, 2'b00, 1);

      // Unmapped / read-only offsets
      axi_write(5'h14, 32'h99999999, 4'hF, 0, 0, 2'b10, 1);
      axi_write(5'h10, 32'h88888888, 4'hF, 0, 0, 2'b10, 1);
      axi_read(5'h14, 32'h0, 2'b10, 1);
      chk("regs_after_slverr", regs_o, {32'hBEEF0011, 32'hDEAD0011, 32'hFF34FF78, 32'h0101FFFF});
`ifdef AXIL_REG_BANK_STATUS_EN
      axi_read(5'h10, 32'hCAFEF00D, 2'b00, 1);
`else
      axi_read(5'h10, 32'h0, 2'b10, 1);
`endif

      // Back-pressure on B and R
      S_AXI_BREADY = 1'b0;
      axi_write(5'h0C, 32'h5555AAAA, 4'hF, 0, 0, 2'b00, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge ACLK);
         chk("b_stall", 128'({S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY}),
             128'(5'b1_00_00));
         @(posedge ACLK); #1;
      end
      S_AXI_BREADY = 1'b1;
      wait_b();
      S_AXI_RREADY = 1'b0;
      axi_read(5'h0C, 32'h5555AAAA, 2'b00, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge ACLK);
         chk("r_stall", 128'({S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_ARREADY}),
             128'({1'b1, 32'h5555AAAA, 2'b00, 1'b0}));
         @(posedge ACLK); #1;
      end
      S_AXI_RREADY = 1'b1;
      wait_r();

      // Read and write to reg0 handshake in the same cycle
      fork
         axi_write(5'h00, 32'h11112222, 4'hF, 0, 0, 2'b00, 1);
         axi_read(5'h00, 32'h0101FFFF, 2'b00, 1);
      join
      axi_read(5'h00, 32'h11112222, 2'b00, 1);

      // Reset while a write response is pending
      S_AXI_BREADY = 1'b0;
      axi_write(5'h04, 32'h77777777, 4'hF, 0, 0, 2'b00, 0);
      @(negedge ACLK);
      chk("bvalid_pre_rst", 128'(S_AXI_BVALID), 128'(1));
      @(posedge ACLK); #1 ARESET = 1'b1;
      exp_b.delete();
      @(posedge ACLK); @(negedge ACLK);
      chk("rst_bvalid", 128'({S_AXI_BVALID, S_AXI_AWREADY}), 128'(2'b00));
      chk("rst_regs2", regs_o, 128'(0));
      @(posedge ACLK); #1 ARESET = 1'b0; S_AXI_BREADY = 1'b1;
      @(posedge ACLK); @(negedge ACLK);
      chk("post_rst_ready2", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(3'b111));
      @(posedge ACLK); #1;
      axi_read(5'h04, 32'h0, 2'b00, 1);

      repeat (3) @(posedge ACLK);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axil_reg_bank.md
AXIL_REG_BANK -- requirements
Module: axil_reg_bank

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32, data bus width; only 32 is supported.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 5, byte-address width.
REQ-003 Parameter C_NUM_REGS, default 4, number of R/W registers at offsets 0x00, 0x04, 0x08, 0x0C.
REQ-004 Parameter C_RESET_VAL, default 32'h0, reset value of every R/W register.
REQ-005 ACLK  in  1  single clock; all logic is on its rising edge.
REQ-006 ARESET  in  1  synchronous, active-high reset.
REQ-007 S_AXI_AWADDR/AWPROT/AWVALID in, AWREADY out  5/3/1/1  write-address channel.
REQ-008 S_AXI_WDATA/WSTRB/WVALID in, WREADY out  32/4/1/1  write-data channel.
REQ-009 S_AXI_BRESP/BVALID out, BREADY in  2/1/1  write-response channel.
REQ-010 S_AXI_ARADDR/ARPROT/ARVALID in, ARREADY out  5/3/1/1  read-address channel.
REQ-011 S_AXI_RDATA/RRESP/RVALID out, RREADY in  32/2/1/1  read-data channel.
REQ-012 regs_o  out  32*C_NUM_REGS  flat register contents, reg0 in bits [31:0].
REQ-013 status_i  in  32  read-only status word (used only with AXIL_REG_BANK_STATUS_EN).

Function
REQ-014 Write FSM states: W_IDLE, W_RESP.
REQ-015 In W_IDLE, AWREADY is high until the AW beat is captured and WREADY is high until the W beat is captured; the two channels are accepted independently in either order or in the same cycle.
REQ-016 Once both beats are held, the write commits in that cycle, the FSM moves to W_RESP, and BVALID is high on the next cycle.
REQ-017 Byte lane n is updated only when WSTRB[n]=1; WSTRB=0 performs no update and still responds OKAY.
REQ-018 Address decode uses AWADDR[4:2]; AWADDR[1:0] and AWPROT are ignored.
REQ-019 An in-range write gives BRESP=OKAY (2'b00); a write to an unmapped or read-only offset gives BRESP=SLVERR (2'b10) and changes no register.
REQ-020 BVALID holds with stable BRESP until BREADY=1, then the FSM returns to W_IDLE; AWREADY/WREADY stay low throughout W_RESP.
REQ-021 Read FSM states: R_IDLE, R_DATA; ARREADY is high only in R_IDLE.
REQ-022 On an AR handshake the FSM registers RDATA/RRESP and enters R_DATA; RVALID is high on the next cycle (1-cycle latency).
REQ-023 RDATA/RRESP hold until RREADY=1, then the FSM returns to R_IDLE; back-to-back reads therefore take at least 2 cycles each.
REQ-024 An unmapped read returns RDATA=0 and RRESP=SLVERR.
REQ-025 If a read and a write to the same register handshake in the same cycle, the read returns the pre-write value.
REQ-026 The read and write FSMs are fully independent; neither stalls the other.

Reset
REQ-027 While ARESET=1: every register = C_RESET_VAL, both FSMs are IDLE, AWREADY/WREADY/ARREADY/BVALID/RVALID = 0, BRESP/RRESP/RDATA = 0.
REQ-028 Reset mid-transaction discards any captured AW/W beat and any pending response; the first READY is asserted on the first cycle after ARESET falls.

Configuration
REQ-029 Macro AXIL_REG_BANK_STATUS_EN.
- Defined: offset 0x10 reads status_i with OKAY; a write to 0x10 gives SLVERR.
- Undefined: 0x10 is unmapped, status_i is unused, and a read gives 0 with SLVERR.

Structure
REQ-030 Package axil_pkg holds the RESP_OKAY/RESP_SLVERR constants, the register offset constants and the FSM state typedefs.
REQ-031 One sub-module, axil_wstrb_merge, performs the combinational byte-lane merge of old data, WDATA and WSTRB.

Verification
REQ-032 Write 0x0101FFFF to 0x00 with WSTRB=F, then read 0x00 -> BRESP=0, RDATA=0x0101FFFF, RRESP=0.
REQ-033 Write 0xABCD0001, 0xDEAD0011 and 0xBEEF0011 to 0x04, 0x08 and 0x0C with W presented 3 cycles before AW -> all OKAY; regs_o matches and readback is equal.
REQ-034 Write 0x12345678 with WSTRB=4'b0101 over a register holding 0xFFFFFFFF -> readback 0xFF34FF78.
REQ-035 Write to and read from 0x14 -> BRESP=SLVERR, RDATA=0, RRESP=SLVERR, no register changed; read 0x10 gives status_i and OKAY with the macro defined, SLVERR without it.
REQ-036 Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID and data remain stable and no new AW/AR is accepted.
REQ-037 Assert ARESET while BVALID=1 -> BVALID drops next cycle and all registers return to C_RESET_VAL.
